sdram_arbiter: RTL and testbench

SDRAM_ARBITER -- requirements
Module: sdram_arbiter

---
 rtl/sdram_arbiter_if.sv | 46 ++++
 rtl/sdram_arbiter.sv | 87 ++++++++
 tb/tb_sdram_arbiter.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/sdram_arbiter_if.sv
// sdram_arbiter_if: bundle of master request/response and SDRAM controller signals
// Masters 0..2: mN_request/addr/write/burst/byte_enable/wdata in; mN_ack/rdvalid/complete out; shared m_rdata.
// Controller: sdram_req (one-hot grant) and granted fields out; sdram_ack/rdata/rdvalid/complete in; err_underflow status.
// slave = arbiter view, master = environment view.
interface sdram_arbiter_if;
   logic        m0_request, m1_request, m2_request;
   logic [25:0] m0_addr, m1_addr, m2_addr;
   logic        m0_write, m1_write, m2_write;
   logic        m0_burst, m1_burst, m2_burst;
   logic [3:0]  m0_byte_enable, m1_byte_enable, m2_byte_enable;
   logic [31:0] m0_wdata, m1_wdata, m2_wdata;
   logic        m0_ack, m1_ack, m2_ack;
   logic        m0_rdvalid, m1_rdvalid, m2_rdvalid;
   logic        m0_complete, m1_complete, m2_complete;
   logic [31:0] m_rdata;
   logic [2:0]  sdram_req;
   logic [25:0] sdram_addr;
   logic        sdram_write, sdram_burst;
   logic [3:0]  sdram_byte_enable;
   logic [31:0] sdram_wdata;
   logic        sdram_ack;
   logic [31:0] sdram_rdata;
   logic [2:0]  sdram_rdvalid;
   logic        sdram_complete;
   logic        err_underflow;
   modport slave (
      input  m0_request, m1_request, m2_request, m0_addr, m1_addr, m2_addr,
      input  m0_write, m1_write, m2_write, m0_burst, m1_burst, m2_burst,
      input  m0_byte_enable, m1_byte_enable, m2_byte_enable, m0_wdata, m1_wdata, m2_wdata,
      output m0_ack, m1_ack, m2_ack, m0_rdvalid, m1_rdvalid, m2_rdvalid,
      output m0_complete, m1_complete, m2_complete, m_rdata,
      output sdram_req, sdram_addr, sdram_write, sdram_burst, sdram_byte_enable, sdram_wdata,
      input  sdram_ack, sdram_rdata, sdram_rdvalid, sdram_complete,
      output err_underflow
   );
   modport master (
      output m0_request, m1_request, m2_request, m0_addr, m1_addr, m2_addr,
      output m0_write, m1_write, m2_write, m0_burst, m1_burst, m2_burst,
      output m0_byte_enable, m1_byte_enable, m2_byte_enable, m0_wdata, m1_wdata, m2_wdata,
      input  m0_ack, m1_ack, m2_ack, m0_rdvalid, m1_rdvalid, m2_rdvalid,
      input  m0_complete, m1_complete, m2_complete, m_rdata,
      input  sdram_req, sdram_addr, sdram_write, sdram_burst, sdram_byte_enable, sdram_wdata,
      output sdram_ack, sdram_rdata, sdram_rdvalid, sdram_complete,
      input  err_underflow
   );
endinterface

// File: rtl/sdram_arbiter.sv
// sdram_arbiter: three-master SDRAM arbiter with outstanding-read completion routing
// Ports: clock, reset (synchronous, active-high), bus (sdram_arbiter_if.slave).
// Build option SDRAM_ARB_ROUND_ROBIN_EN selects round-robin grant; otherwise fixed priority m0 > m1 > m2.
module sdram_arbiter (
   input logic            clock,
   input logic            reset,
   sdram_arbiter_if.slave bus
);
   typedef enum logic {IDLE, GRANTED} state_t;
   state_t      state_q, state_d;
   logic [2:0]  g_q, g_d, req, wr, elig, win, cnt_q;
   logic [1:0]  fifo_q [4];
   logic [1:0]  wp_q, rp_q, head, gid;
   logic        err_q, push, pop, full;
   assign req  = {bus.m2_request, bus.m1_request, bus.m0_request};
   assign wr   = {bus.m2_write, bus.m1_write, bus.m0_write};
   assign full = cnt_q == 3'd4;
   // reads are held off while the outstanding-read FIFO is full, so a push can never overflow it
   assign elig = req & (wr | {3{!full}});
   assign gid  = g_q[1] ? 2'd1 : g_q[2] ? 2'd2 : 2'd0;
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
   logic [1:0] p_q;
   logic [2:0] idx;
   // scan from the farthest candidate back to p so the first eligible at or after p wins
   always_comb begin
      win = '0;
      idx = '0;
      for (int i = 2; i >= 0; i--) begin
         idx = {1'b0, p_q} + 3'(i);
         idx = idx >= 3'd3 ? idx - 3'd3 : idx;
         if (elig[idx[1:0]]) win = 3'b001 << idx[1:0];
      end
   end
   always_ff @(posedge clock)
      if (reset) p_q <= '0;
      else if (state_q == GRANTED && bus.sdram_ack) p_q <= gid == 2'd2 ? 2'd0 : gid + 2'd1;
`else
   assign win = elig[0] ? 3'b001 : elig[1] ? 3'b010 : elig[2] ? 3'b100 : 3'b000;
`endif
   always_comb begin
      state_d = state_q;
      g_d     = g_q;
      if (state_q == IDLE) begin
         state_d = win != 3'b000 ? GRANTED : IDLE;
         g_d     = win;
      end else if (bus.sdram_ack) begin
         state_d = IDLE;
         g_d     = '0;
      end
   end
   assign push = state_q == GRANTED && bus.sdram_ack && !bus.sdram_write;
   // a complete against an empty FIFO is an underflow, even if a push lands in the same cycle
   assign pop  = bus.sdram_complete && cnt_q != 3'd0;
   assign head = fifo_q[rp_q];
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         g_q     <= '0;
         wp_q    <= '0;
         rp_q    <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         g_q     <= g_d;
         if (push) begin
            fifo_q[wp_q] <= gid;
            wp_q         <= wp_q + 2'd1;
         end
         if (pop) rp_q <= rp_q + 2'd1;
         cnt_q <= cnt_q + 3'(push) - 3'(pop);
         if (bus.sdram_complete && cnt_q == 3'd0) err_q <= 1'b1;
      end
   end
   assign bus.sdram_req         = g_q;
   assign bus.sdram_addr        = g_q[1] ? bus.m1_addr : g_q[2] ? bus.m2_addr : bus.m0_addr;
   assign bus.sdram_write       = g_q[1] ? bus.m1_write : g_q[2] ? bus.m2_write : bus.m0_write;
   assign bus.sdram_burst       = g_q[1] ? bus.m1_burst : g_q[2] ? bus.m2_burst : bus.m0_burst;
   assign bus.sdram_byte_enable = g_q[1] ? bus.m1_byte_enable : g_q[2] ? bus.m2_byte_enable : bus.m0_byte_enable;
   assign bus.sdram_wdata       = g_q[1] ? bus.m1_wdata : g_q[2] ? bus.m2_wdata : bus.m0_wdata;
   // handshakes are masked during reset so a discarded grant or FIFO never signals a master
   assign {bus.m2_ack, bus.m1_ack, bus.m0_ack} = {3{bus.sdram_ack && !reset}} & g_q;
   assign {bus.m2_complete, bus.m1_complete, bus.m0_complete} = {3{pop && !reset}} & (3'b001 << head);
   assign {bus.m2_rdvalid, bus.m1_rdvalid, bus.m0_rdvalid} = bus.sdram_rdvalid;
   assign bus.m_rdata       = bus.sdram_rdata;
   assign bus.err_underflow = err_q;
endmodule

// File: tb/tb_sdram_arbiter.sv
// tb_sdram_arbiter: scoreboard bench for sdram_arbiter against a queue-based reference model
module tb_sdram_arbiter;
   logic clock = 1'b0;
   logic reset = 1'b1;
   sdram_arbiter_if bus ();
   sdram_arbiter dut (.clock(clock), .reset(reset), .bus(bus));
   always #5 clock = ~clock;

   typedef struct {
      int          id;
      logic [25:0] addr;
      logic        wr, bu;
      logic [3:0]  be;
      logic [31:0] wd;
      int          cyc;
   } grant_t;
   grant_t      exp_grant[$];
   int          exp_cpl[$];
   logic [34:0] exp_rd[$];
   int          mfifo[$];
   int          checks = 0, errors = 0, cyc = 0, gid = 0, p = 0;
   bit          busy = 0, err_state = 0, err_vis = 0, mon_on = 0;
   logic [2:0]  exp_ack = '0, prev_req = '0, mon_v;
   grant_t      mon_e;
   logic        req[3], wr[3], bu[3];
   logic [25:0] addr[3];
   logic [3:0]  be[3];
   logic [31:0] wd[3];
   bit          ack_done[3];

   assign bus.m0_request = req[0];
   assign bus.m1_request = req[1];
   assign bus.m2_request = req[2];
   assign bus.m0_addr = addr[0];
   assign bus.m1_addr = addr[1];
   assign bus.m2_addr = addr[2];
   assign bus.m0_write = wr[0];
   assign bus.m1_write = wr[1];
   assign bus.m2_write = wr[2];
   assign bus.m0_burst = bu[0];
   assign bus.m1_burst = bu[1];
   assign bus.m2_burst = bu[2];
   assign bus.m0_byte_enable = be[0];
   assign bus.m1_byte_enable = be[1];
   assign bus.m2_byte_enable = be[2];
   assign bus.m0_wdata = wd[0];
   assign bus.m1_wdata = wd[1];
   assign bus.m2_wdata = wd[2];

   always @(posedge clock) cyc <= cyc + 1;

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference model: evaluates one cycle from the inputs the bench is driving right now.
   task automatic model_eval();
      int win;
      bit was_busy;
      win      = -1;
      was_busy = busy;
      err_vis  = err_state;
      exp_ack  = '0;
      if (reset) begin
         busy = 0;
         mfifo.delete();
         p = 0;
         err_state = 0;
         return;
      end
      if (!busy) begin
         for (int k = 2; k >= 0; k--) begin
            int i;
            i = (p + k) % 3;
            if (req[i] && (wr[i] || mfifo.size() < 4)) win = i;
         end
         if (win >= 0) begin
            busy = 1;
            gid  = win;
            exp_grant.push_back('{win, addr[win], wr[win], bu[win], be[win], wd[win], cyc + 1});
         end
      end
      if (bus.sdram_complete) begin
         if (mfifo.size() > 0) exp_cpl.push_back(mfifo.pop_front());
         else err_state = 1;
      end
      if (was_busy && bus.sdram_ack) begin
         exp_ack = 3'b001 << gid;
         if (!wr[gid]) mfifo.push_back(gid);
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
         p = (gid + 1) % 3;
`endif
         busy = 0;
         ack_done[gid] = 1;
      end
      if (bus.sdram_rdvalid != 3'b000) exp_rd.push_back({bus.sdram_rdvalid, bus.sdram_rdata});
   endtask

   task automatic cycle();
      model_eval();
      @(posedge clock);
      #1;
      bus.sdram_ack = 1'b0;
      bus.sdram_complete = 1'b0;
      bus.sdram_rdvalid = 3'b000;
      for (int i = 0; i < 3; i++)
         if (ack_done[i]) begin
            req[i] = 1'b0;
            ack_done[i] = 0;
         end
   endtask

   task automatic set_m(int i, logic w, logic [25:0] a, logic [3:0] b, logic [31:0] d);
      req[i]  = 1'b1;
      wr[i]   = w;
      addr[i] = a;
      be[i]   = b;
      wd[i]   = d;
      bu[i]   = 1'($urandom_range(1));
   endtask

   // Monitor: compares DUT outputs against the scoreboard queues mid-cycle.
   always @(negedge clock) if (mon_on) begin
      if (bus.sdram_req != 3'b000 && prev_req == 3'b000) begin
         if (exp_grant.size() == 0) chk("grant_unexpected", 64'(bus.sdram_req), 64'd0);
         else begin
            mon_e = exp_grant.pop_front();
            chk("grant_req", 64'(bus.sdram_req), 64'(3'b001 << mon_e.id));
            chk("grant_cycle", 64'(cyc), 64'(mon_e.cyc));
            chk("grant_addr", 64'(bus.sdram_addr), 64'(mon_e.addr));
            chk("grant_ctl", 64'({bus.sdram_write, bus.sdram_burst, bus.sdram_byte_enable}),
                64'({mon_e.wr, mon_e.bu, mon_e.be}));
            chk("grant_wdata", 64'(bus.sdram_wdata), 64'(mon_e.wd));
         end
      end
      prev_req = bus.sdram_req;
      chk("ack", 64'({bus.m2_ack, bus.m1_ack, bus.m0_ack}), 64'(exp_ack));
      mon_v = {bus.m2_complete, bus.m1_complete, bus.m0_complete};
      if (mon_v != 3'b000) begin
         if (exp_cpl.size() == 0) chk("complete_unexpected", 64'(mon_v), 64'd0);
         else chk("complete", 64'(mon_v), 64'(3'b001 << exp_cpl.pop_front()));
      end
      mon_v = {bus.m2_rdvalid, bus.m1_rdvalid, bus.m0_rdvalid};
      if (mon_v != 3'b000) begin
         if (exp_rd.size() == 0) chk("rdvalid_unexpected", 64'(mon_v), 64'd0);
         else chk("rdvalid_rdata", 64'({mon_v, bus.m_rdata}), 64'(exp_rd.pop_front()));
      end
      chk("err_underflow", 64'(bus.err_underflow), 64'(err_vis));
   end

   initial begin
      for (int i = 0; i < 3; i++) begin
         req[i] = 1'b0; wr[i] = 1'b0; bu[i] = 1'b0; addr[i] = '0; be[i] = '0; wd[i] = '0; ack_done[i] = 0;
      end
      bus.sdram_ack = 1'b0;
      bus.sdram_complete = 1'b0;
      bus.sdram_rdvalid = 3'b000;
      bus.sdram_rdata = '0;
      cycle();
      mon_on = 1;
      repeat (2) cycle();
      reset = 1'b0;
      chk("reset_req", 64'(bus.sdram_req), 64'd0);
      chk("reset_err", 64'(bus.err_underflow), 64'd0);
      // single read by m1, acked then completed
      set_m(1, 1'b0, 26'h0000100, 4'hF, 32'h0);
      cycle();
      bus.sdram_ack = 1'b1;
      cycle();
      cycle();
      bus.sdram_complete = 1'b1;
      cycle();
      // all three requesting continuously, every grant acked
      for (int k = 0; k < 4; k++) begin
         for (int i = 0; i < 3; i++)
            if (!req[i]) set_m(i, 1'b1, 26'($urandom), 4'($urandom), $urandom);
         cycle();
         bus.sdram_ack = 1'b1;
         cycle();
      end
      for (int i = 0; i < 3; i++) req[i] = 1'b0;
      cycle();
      // m2 partial write
      set_m(2, 1'b1, 26'($urandom), 4'b0011, 32'hDEADBEEF);
      cycle();
      bus.sdram_ack = 1'b1;
      cycle();
      cycle();
      // fill the read FIFO, then an m0 read must wait for a completion
      for (int k = 0; k < 4; k++) begin
         set_m(1, 1'b0, 26'($urandom), 4'hF, 32'h0);
         cycle();
         bus.sdram_ack = 1'b1;
         cycle();
      end
      set_m(0, 1'b0, 26'($urandom), 4'hF, 32'h0);
      repeat (3) cycle();
      bus.sdram_complete = 1'b1;
      cycle();
      cycle();
      bus.sdram_ack = 1'b1;
      cycle();
      repeat (4) begin
         bus.sdram_complete = 1'b1;
         cycle();
      end
      // tagged read data pass-through
      bus.sdram_rdvalid = 3'b100;
      bus.sdram_rdata = 32'h12345678;
      cycle();
      // randomized traffic
      repeat (3000) begin
         for (int i = 0; i < 3; i++)
            if (!req[i] && $urandom_range(2) == 0)
               set_m(i, 1'($urandom_range(1)), 26'($urandom), 4'($urandom), $urandom);
         if (busy && $urandom_range(1) == 1) bus.sdram_ack = 1'b1;
         if (mfifo.size() > 0 && $urandom_range(2) == 0) bus.sdram_complete = 1'b1;
         if ($urandom_range(3) == 0) begin
            bus.sdram_rdvalid = 3'b001 << $urandom_range(2);
            bus.sdram_rdata = $urandom;
         end
         cycle();
      end
      for (int i = 0; i < 3; i++) if (!(busy && gid == i)) req[i] = 1'b0;
      if (busy) bus.sdram_ack = 1'b1;
      cycle();
      for (int k = 0; k < 4; k++)
         if (mfifo.size() > 0) begin
            bus.sdram_complete = 1'b1;
            cycle();
         end
      cycle();
      // push and complete together on an empty FIFO: underflow, entry kept
      set_m(0, 1'b0, 26'($urandom), 4'hF, 32'h0);
      cycle();
      bus.sdram_ack = 1'b1;
      bus.sdram_complete = 1'b1;
      cycle();
      cycle();
      bus.sdram_complete = 1'b1;
      cycle();
      repeat (3) cycle();
      // reset with a read outstanding and a grant held
      set_m(1, 1'b0, 26'($urandom), 4'hF, 32'h0);
      cycle();
      bus.sdram_ack = 1'b1;
      cycle();
      set_m(2, 1'b0, 26'($urandom), 4'hF, 32'h0);
      cycle();
      cycle();
      for (int i = 0; i < 3; i++) req[i] = 1'b0;
      reset = 1'b1;
      bus.sdram_complete = 1'b1;
      cycle();
      reset = 1'b0;
      cycle();
      chk("post_reset_req", 64'(bus.sdram_req), 64'd0);
      bus.sdram_complete = 1'b1;
      cycle();
      repeat (2) cycle();
      chk("grant_queue_drained", 64'(exp_grant.size()), 64'd0);
      chk("complete_queue_drained", 64'(exp_cpl.size()), 64'd0);
      chk("rdvalid_queue_drained", 64'(exp_rd.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
